ltc2308_ctrl: RTL and testbench
===============================

// Module: ltc2308_ctrl
// PURPOSE
//  Sequencing controller for the DE10-Nano LTC2308 8-ch 12-bit SAR ADC. Free-runs conversion frames
//  while enabled and round-robins over the channels set in ch_mask. Drives CONVST/SCK/SDI, shifts the
//  SDO result in and emits a one-cycle result strobe tagged with the channel it belongs to.
//  Sits between the ADC pins and the capture/JTAG readout logic.
// PARAMETERS (all in clk cycles; defaults for 50 MHz clk = 20 ns)
//  CONVST_HI_CYC  1    CONVST high width; legal 20..40 ns.
//  CONV_CYC       80   CONVST rise -> first SCK activity; >= tCONV max 1.6 us.
//  SCK_HALF_CYC   1    SCK low and high width; >= 10 ns each, period >= 25 ns.
//  CYCLE_CYC      110  CONVST rise -> next CONVST rise; >= 2 us and >= CONV_CYC+24*SCK_HALF_CYC+2.
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous active-low reset
//  enable        in   1   1 = run frames; sampled at frame start
//  ch_mask       in   8   enabled channels; sampled at frame start
//  uni           in   1   1 = unipolar, 0 = bipolar (UNI bit of config word)
//  adc_convst    out  1   ADC CONVST
//  adc_sck       out  1   ADC SCK, idles low
//  adc_sdi       out  1   ADC SDI, config word MSB first
//  adc_sdo       in   1   ADC SDO
//  busy          out  1   1 while a frame is in progress
//  result_valid  out  1   one-cycle strobe
//  result_data   out  12  conversion result, held until next strobe
//  result_ch     out  3   channel of result_data
// BEHAVIOUR
//  - Reset, asynchronous: every output is 0. Also clears the state, the counters and prev_valid.
//  - States: IDLE, CONV_HI, CONV_WAIT, SHIFT, GAP. frame_cnt runs from 0 at CONVST rise.
//  - IDLE: moves to CONV_HI when enable=1 and ch_mask!=0. On that edge it latches the mask, picks the
//    next channel and loads the 6-bit config word {S/D=1, O/S=ch[0], S1=ch[2], S0=ch[1], UNI=uni, SLP=0}.
//  - CONV_HI: adc_convst=1 for CONVST_HI_CYC cycles, then -> CONV_WAIT.
//  - CONV_WAIT: adc_convst=0, sck=0. Moves to SHIFT at frame_cnt==CONV_CYC.
//  - SHIFT: 12 bits. Each bit is SCK low for SCK_HALF_CYC, then high for SCK_HALF_CYC.
//    - adc_sdi is updated at the start of each low phase: cfg[5..0] for bits 0..5, 0 for bits 6..11.
//    - adc_sdo is captured into the shift register, MSB first, on the clk edge that drives SCK high.
//    - After the 12th falling edge -> GAP.
//  - Pipeline: the LTC2308 converts frame N with the config shifted in frame N-1.
//    - prev_ch/prev_valid hold the config sent in the last frame.
//    - One cycle after entering GAP: if prev_valid, result_valid=1, result_data=shift reg, result_ch=prev_ch.
//    - Then prev_ch<=cur_ch and prev_valid<=1.
//  - GAP: at frame_cnt==CYCLE_CYC-1 the next clock edge either starts a new frame (enable && mask!=0,
//    directly to CONV_HI) or goes to IDLE and clears prev_valid.
//  - Round-robin: next channel is the lowest set bit of the mask strictly above prev_ch, wrapping to
//    bit 0. The first frame after IDLE starts from the lowest set bit.
//  - enable dropping mid-frame: the current frame completes, its result is still delivered, then IDLE.
//  - ch_mask change mid-frame takes effect at the next frame start.
//  - busy=1 in CONV_HI through GAP, 0 in IDLE. adc_sck=0 outside SHIFT.
//  - No SCK edge occurs before CONV_CYC cycles after the CONVST rise.
//  - CONVST stays low from the end of CONV_HI until the next frame.
// STRUCTURE
//  - ltc2308_pkg: state enum; config-word bit indices (SD, OS, S1, S0, UNI, SLP); NUM_BITS=12; CFG_BITS=6.
//  - Sub-module ltc2308_rr_pick: combinational; inputs mask[7:0], cur[2:0], first; outputs next[2:0].
//  - Top: FSM, frame_cnt, half-period counter, bit counter, SDI/SDO shift registers, result registers.
// TESTING (clk 20 ns, default params, SDO model returns a programmed 12-bit value per channel)
//  1. rst_n=0 then 1 with enable=0 -> all outputs 0, busy=0, no CONVST for 10 us.
//  2. enable=1, mask=8'h01, uni=1, ch0=12'hA5C -> SDI bits 100010 every frame.
//     CONVST rise-to-rise exactly 110 cycles. Frame 1 has no strobe; frame 2 strobe gives data=A5C, ch=0.
//  3. mask=8'b1010_0100 -> configured channel sequence 2,5,7,2,5.
//     Result tags 2,5,7,2 start from frame 2, each with the matching programmed value.
//  4. Attach the LTC2308 pin timing checker (tWHCONV, tCYC, tCONV, SCK high/low/period) for 50 frames
//     -> no violation.
//  5. Drop enable mid-SHIFT of frame 3 -> frame 3 strobe still occurs, then IDLE, busy=0.
//     Re-enable -> the first new frame gives no strobe.
//  6. Assert rst_n mid-SHIFT -> outputs 0 in the same timestep, no strobe.
//     After release with enable=1 -> the first frame restarts at the lowest mask bit with no strobe.

Source files
------------

// File: rtl/ltc2308_pkg.sv
// ============================================================================
//  Module   : ltc2308_pkg
//  Purpose  : Shared types and constants for the LTC2308 sequencing controller
//  Revision : 1.0
// ============================================================================
`default_nettype none

package ltc2308_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONV_HI   = 3'd1,
        ST_CONV_WAIT = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    localparam int NUM_BITS = 12;
    localparam int CFG_BITS = 6;

    // Bit positions inside the 6-bit config word, MSB shifted first
    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;

    function automatic logic [CFG_BITS-1:0] make_cfg(input logic [2:0] ch, input logic uni);
        logic [CFG_BITS-1:0] c;
        c          = '0;
        c[CFG_SD]  = 1'b1;
        c[CFG_OS]  = ch[0];
        c[CFG_S1]  = ch[2];
        c[CFG_S0]  = ch[1];
        c[CFG_UNI] = uni;
        c[CFG_SLP] = 1'b0;
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ltc2308_ctrl_rr_pick.sv
// ============================================================================
//  Module   : ltc2308_ctrl_rr_pick
//  Purpose  : Round-robin channel picker (lowest set mask bit above cur, wrapping)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ltc2308_ctrl_rr_pick (
    input  logic [7:0] i_mask,
    input  logic [2:0] i_cur,
    input  logic       i_first,
    output logic [2:0] o_next
);

    logic       w_found;
    logic [2:0] w_idx;

    // Offsets 1..8 from cur; offset 8 wraps back onto cur itself
    always_comb begin
        o_next  = 3'd0;
        w_found = 1'b0;
        w_idx   = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            w_idx = i_first ? 3'(i - 1) : (i_cur + 3'(i));
            if (!w_found && i_mask[w_idx]) begin
                o_next  = w_idx;
                w_found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ltc2308_ctrl.sv
// ============================================================================
//  Module   : ltc2308_ctrl
//  Purpose  : LTC2308 frame sequencer: CONVST/SCK/SDI drive, SDO capture, tagged results
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ltc2308_ctrl
    import ltc2308_pkg::*;
#(
    parameter int CONVST_HI_CYC = 1,
    parameter int CONV_CYC      = 80,
    parameter int SCK_HALF_CYC  = 1,
    parameter int CYCLE_CYC     = 110
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    input  logic [7:0]  i_ch_mask,
    input  logic        i_uni,
    output logic        o_adc_convst,
    output logic        o_adc_sck,
    output logic        o_adc_sdi,
    input  logic        i_adc_sdo,
    output logic        o_busy,
    output logic        o_result_valid,
    output logic [11:0] o_result_data,
    output logic [2:0]  o_result_ch
);

    localparam int CNT_W  = $clog2(CYCLE_CYC + 1);
    localparam int HALF_W = $clog2(SCK_HALF_CYC + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_frame_cnt;
    logic [HALF_W-1:0]     r_half;
    logic                  r_phase;
    logic [3:0]            r_bit;
    logic [CFG_BITS-1:0]   r_cfg;
    logic [NUM_BITS-2:0]   r_sdi_sh;
    logic [NUM_BITS-1:0]   r_sdo_sh;
    logic [2:0]            r_cur_ch;
    logic [2:0]            r_prev_ch;
    logic                  r_prev_valid;
    logic                  r_deliver;
    logic                  r_convst;
    logic                  r_sck;
    logic                  r_sdi;
    logic                  r_busy;
    logic                  r_valid;
    logic [11:0]           r_data;
    logic [2:0]            r_res_ch;

    logic                  w_go;
    logic                  w_frame_start;
    logic                  w_shift_start;
    logic                  w_half_end;
    logic                  w_last_bit;
    logic [2:0]            w_next_ch;

    ltc2308_ctrl_rr_pick u_rr_pick (
        .i_mask  (i_ch_mask),
        .i_cur   (r_prev_ch),
        .i_first (r_state == ST_IDLE),
        .o_next  (w_next_ch)
    );

    assign w_go          = i_enable && (i_ch_mask != 8'd0);
    assign w_half_end    = (r_half == HALF_W'(SCK_HALF_CYC - 1));
    assign w_last_bit    = (r_bit == 4'(NUM_BITS - 1));
    assign w_shift_start = (r_state == ST_CONV_WAIT) && (r_frame_cnt == CNT_W'(CONV_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_state_nxt   = ST_CONV_HI;
                    w_frame_start = 1'b1;
                end
            end
            ST_CONV_HI: begin
                if (r_frame_cnt == CNT_W'(CONVST_HI_CYC - 1)) begin
                    w_state_nxt = ST_CONV_WAIT;
                end
            end
            ST_CONV_WAIT: begin
                if (w_shift_start) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_phase && w_half_end && w_last_bit) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_frame_cnt == CNT_W'(CYCLE_CYC - 1)) begin
                    if (w_go) begin
                        w_state_nxt   = ST_CONV_HI;
                        w_frame_start = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt  <= '0;
            r_half       <= '0;
            r_phase      <= 1'b0;
            r_bit        <= 4'd0;
            r_cfg        <= '0;
            r_sdi_sh     <= '0;
            r_sdo_sh     <= '0;
            r_cur_ch     <= 3'd0;
            r_prev_ch    <= 3'd0;
            r_prev_valid <= 1'b0;
            r_deliver    <= 1'b0;
            r_convst     <= 1'b0;
            r_sck        <= 1'b0;
            r_sdi        <= 1'b0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_data       <= 12'd0;
            r_res_ch     <= 3'd0;
        end else begin
            r_convst <= (w_state_nxt == ST_CONV_HI);
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_valid  <= 1'b0;

            if (w_frame_start) begin
                r_frame_cnt <= '0;
                r_cur_ch    <= w_next_ch;
                r_cfg       <= make_cfg(w_next_ch, i_uni);
            end else if (r_state != ST_IDLE) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end

            if (w_shift_start) begin
                r_half   <= '0;
                r_phase  <= 1'b0;
                r_bit    <= 4'd0;
                r_sck    <= 1'b0;
                r_sdi    <= r_cfg[CFG_BITS-1];
                r_sdi_sh <= {r_cfg[CFG_BITS-2:0], {(NUM_BITS - CFG_BITS){1'b0}}};
            end else if (r_state == ST_SHIFT) begin
                if (!w_half_end) begin
                    r_half <= r_half + HALF_W'(1);
                end else begin
                    r_half <= '0;
                    if (!r_phase) begin
                        r_phase  <= 1'b1;
                        r_sck    <= 1'b1;
                        r_sdo_sh <= {r_sdo_sh[NUM_BITS-2:0], i_adc_sdo};
                    end else begin
                        r_phase <= 1'b0;
                        r_sck   <= 1'b0;
                        if (w_last_bit) begin
                            r_sdi     <= 1'b0;
                            r_deliver <= 1'b1;
                        end else begin
                            r_bit    <= r_bit + 4'd1;
                            r_sdi    <= r_sdi_sh[NUM_BITS-2];
                            r_sdi_sh <= {r_sdi_sh[NUM_BITS-3:0], 1'b0};
                        end
                    end
                end
            end

            // Data shifted in this frame answers the config sent in the previous one
            if (r_deliver) begin
                r_deliver <= 1'b0;
                if (r_prev_valid) begin
                    r_valid  <= 1'b1;
                    r_data   <= r_sdo_sh;
                    r_res_ch <= r_prev_ch;
                end
                r_prev_ch    <= r_cur_ch;
                r_prev_valid <= 1'b1;
            end

            if ((r_state == ST_GAP) && (w_state_nxt == ST_IDLE)) begin
                r_prev_valid <= 1'b0;
            end
        end
    end

    assign o_adc_convst   = r_convst;
    assign o_adc_sck      = r_sck;
    assign o_adc_sdi      = r_sdi;
    assign o_busy         = r_busy;
    assign o_result_valid = r_valid;
    assign o_result_data  = r_data;
    assign o_result_ch    = r_res_ch;

endmodule

`default_nettype wire

// File: tb/tb_ltc2308_ctrl.sv
// ============================================================================
//  Module   : tb_ltc2308_ctrl
//  Purpose  : Scoreboard bench for ltc2308_ctrl with a behavioural LTC2308 pin model
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ltc2308_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_enable;
    logic [7:0]  i_ch_mask;
    logic        i_uni;
    logic        o_adc_convst;
    logic        o_adc_sck;
    logic        o_adc_sdi;
    logic        i_adc_sdo = 1'b0;
    logic        o_busy;
    logic        o_result_valid;
    logic [11:0] o_result_data;
    logic [2:0]  o_result_ch;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] prog [8] = '{12'hA5C, 12'h3C1, 12'h7E2, 12'h0F3,
                              12'h844, 12'hB55, 12'h166, 12'hD97};

    logic [5:0]  exp_cfg [$];
    logic [14:0] exp_res [$];

    int          conv_rises  = 0;
    bit          tcyc_en     = 1'b0;
    longint      last_rise_t = 0;
    int          base;

    always #10 clk = ~clk;

    ltc2308_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_enable       (i_enable),
        .i_ch_mask      (i_ch_mask),
        .i_uni          (i_uni),
        .o_adc_convst   (o_adc_convst),
        .o_adc_sck      (o_adc_sck),
        .o_adc_sdi      (o_adc_sdi),
        .i_adc_sdo      (i_adc_sdo),
        .o_busy         (o_busy),
        .o_result_valid (o_result_valid),
        .o_result_data  (o_result_data),
        .o_result_ch    (o_result_ch)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int tb_next(input logic [7:0] m, input int prev);
        for (int k = 0; k < 8; k++) begin
            int c;
            c = (prev < 0) ? k : (prev + 1 + k) % 8;
            if (m[c]) return c;
        end
        return 0;
    endfunction

    // ADC model: SDI word captured on SCK rise, result of the previous config shifted out on SCK fall
    logic [11:0] sdi_word = '0;
    int          sdi_n    = 0;
    logic [2:0]  cfg_ch   = 3'd0;
    logic [11:0] sdo_sh   = '0;

    always @(posedge o_adc_convst or posedge o_adc_sck or negedge o_adc_sck) begin
        if (o_adc_convst) begin
            conv_rises++;
            sdi_n     = 0;
            sdo_sh    = prog[cfg_ch];
            i_adc_sdo = sdo_sh[11];
        end else if (o_adc_sck) begin
            sdi_word = {sdi_word[10:0], o_adc_sdi};
            sdi_n++;
            if (sdi_n == 12) begin
                cfg_ch = {sdi_word[9], sdi_word[8], sdi_word[10]};
                if (exp_cfg.size() == 0) begin
                    check_eq("cfg_unexpected", 1, 0);
                end else begin
                    check_eq("sdi_word", int'(sdi_word), int'({exp_cfg.pop_front(), 6'b0}));
                end
            end
        end else begin
            sdo_sh    = {sdo_sh[10:0], 1'b0};
            i_adc_sdo = sdo_sh[11];
        end
    end

    always @(posedge o_adc_convst) begin
        if (tcyc_en) begin
            if (last_rise_t != 0) check_eq("tcyc", int'(($time - last_rise_t) / 20), 110);
            last_rise_t = $time;
        end
    end

    always @(negedge clk) begin
        if (o_result_valid) begin
            if (exp_res.size() == 0) begin
                check_eq("strobe_unexpected", 1, 0);
            end else begin
                logic [14:0] e;
                e = exp_res.pop_front();
                check_eq("res_ch", int'(o_result_ch), int'(e[14:12]));
                check_eq("res_data", int'(o_result_data), int'(e[11:0]));
            end
        end
    end

    // Pin timing checker, sampled on the falling clock edge
    logic p_conv = 1'b0;
    logic p_sck  = 1'b0;
    int   since = 0, hi_conv = 0, hi_w = 0, lo_w = 0;
    bit   first_sck = 1'b0;

    always @(negedge clk) begin
        if (o_adc_convst && !p_conv) begin
            since     = 0;
            first_sck = 1'b0;
        end else begin
            since++;
        end
        if (o_adc_convst) hi_conv++;
        else if (p_conv) begin
            check_eq("t_whconv", hi_conv, 1);
            hi_conv = 0;
        end
        if (o_adc_sck && !p_sck) begin
            if (!first_sck) begin
                check_eq("t_conv", int'(since >= 80), 1);
                first_sck = 1'b1;
            end else begin
                check_eq("sck_low", lo_w, 1);
            end
            hi_w = 1;
        end else if (o_adc_sck) begin
            hi_w++;
        end
        if (!o_adc_sck && p_sck) begin
            check_eq("sck_high", hi_w, 1);
            lo_w = 1;
        end else if (!o_adc_sck) begin
            lo_w++;
        end
        p_conv = o_adc_convst;
        p_sck  = o_adc_sck;
    end

    task automatic push_exp(input logic [7:0] m, input logic u, input int n);
        int ch, pch;
        logic [2:0] c3;
        pch = -1;
        for (int f = 0; f < n; f++) begin
            ch = tb_next(m, pch);
            c3 = 3'(ch);
            exp_cfg.push_back({1'b1, c3[0], c3[2], c3[1], u, 1'b0});
            if (f > 0) exp_res.push_back({3'(pch), prog[pch]});
            pch = ch;
        end
    endtask

    task automatic wait_rises(input int target);
        int cyc, lim;
        cyc = 0;
        lim = 150 * (target - conv_rises) + 200;
        while (conv_rises < target && cyc < lim) begin
            @(negedge clk);
            cyc++;
        end
        if (conv_rises < target) check_eq("convst_timeout", conv_rises, target);
    endtask

    task automatic wait_sck_high();
        int cyc;
        cyc = 0;
        while (!o_adc_sck && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!o_adc_sck) check_eq("sck_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (o_busy && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        check_eq("idle_busy", int'(o_busy), 0);
        check_eq("idle_convst", int'(o_adc_convst), 0);
    endtask

    task automatic drain_check();
        check_eq("res_drain", exp_res.size(), 0);
        check_eq("cfg_drain", exp_cfg.size(), 0);
        exp_res.delete();
        exp_cfg.delete();
    endtask

    task automatic run_frames(input logic [7:0] m, input logic u, input int n, input bit drop_in_shift);
        base = conv_rises;
        push_exp(m, u, n);
        i_ch_mask   = m;
        i_uni       = u;
        last_rise_t = 0;
        tcyc_en     = 1'b1;
        i_enable    = 1'b1;
        wait_rises(base + n);
        if (drop_in_shift) wait_sck_high();
        @(negedge clk);
        i_enable = 1'b0;
        wait_idle();
        tcyc_en = 1'b0;
        drain_check();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_convst"}, int'(o_adc_convst), 0);
        check_eq({tag, "_sck"}, int'(o_adc_sck), 0);
        check_eq({tag, "_sdi"}, int'(o_adc_sdi), 0);
        check_eq({tag, "_busy"}, int'(o_busy), 0);
        check_eq({tag, "_valid"}, int'(o_result_valid), 0);
        check_eq({tag, "_data"}, int'(o_result_data), 0);
        check_eq({tag, "_ch"}, int'(o_result_ch), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        i_enable  = 1'b0;
        i_ch_mask = 8'h00;
        i_uni     = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (500) @(negedge clk);
        check_eq("idle_rises", conv_rises, 0);
        check_outputs_zero("idle");

        run_frames(8'h01, 1'b1, 3, 1'b0);
        run_frames(8'hA4, 1'b1, 5, 1'b0);
        run_frames(8'hFF, 1'b0, 50, 1'b0);
        run_frames(8'h06, 1'b1, 3, 1'b1);
        run_frames(8'h06, 1'b1, 2, 1'b0);

        // Reset while shifting frame 2: the frame-1 result must never appear
        push_exp(8'h0C, 1'b1, 1);
        base      = conv_rises;
        i_ch_mask = 8'h0C;
        i_uni     = 1'b1;
        i_enable  = 1'b1;
        wait_rises(base + 2);
        wait_sck_high();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        repeat (3) @(negedge clk);
        check_eq("rst_cfg_drain", exp_cfg.size(), 0);
        check_eq("rst_res_drain", exp_res.size(), 0);
        push_exp(8'h0C, 1'b1, 3);
        base  = conv_rises;
        rst_n = 1'b1;
        wait_rises(base + 3);
        @(negedge clk);
        i_enable = 1'b0;
        wait_idle();
        drain_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
